mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-side executor for the multicycle RISC-V core, directly downstream of the control unit FSM.
- Accepts one fetch, load or store request per transaction while the CU sits in FETCH / MEM_READ / MEM_WRITE.
- Drives a word-addressed, byte-enabled memory bus with a req/ack handshake, and returns aligned, sign-extended load data.
- Raises busy so the CU holds in STALL until a one-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for mem_ack before aborting. Used only with the optional feature; range 1..1023.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CU request strobe; sampled only when busy=0
- req_fetch  in  1  1 = instruction fetch (word access, funct3 ignored)
- req_we  in  1  1 = store, 0 = load; ignored when req_fetch=1
- req_funct3  in  3  access size/sign (RISC-V load/store funct3)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or illegal-size access (or timeout)
- rdata  out  32  load/fetch result; valid from done, held until next done
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  30  word address = req_addr[31:2]
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; mem_rdata valid the same cycle
- mem_rdata  in  32  memory read word

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE; every output 0 (busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata). Reset mid-transaction aborts it: mem_req drops the next edge and no done is issued.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On req_valid, latch all req_* fields and set busy=1.
  - Legal access → REQ; mem_req/mem_we/mem_addr/mem_be/mem_wdata become valid the next cycle.
  - Illegal access → RESP with err=1; no bus activity.
- Illegal access definition:
  - funct3 in {011, 110, 111}.
  - Store with funct3 in {100, 101}.
  - Halfword with addr[0]=1.
  - Word or fetch with addr[1:0]≠00.
- REQ:
  - mem_req=1 and all mem_* outputs stay stable until the cycle mem_ack=1.
  - On ack: capture and format mem_rdata into rdata (loads/fetches only; stores leave rdata unchanged), drop mem_req, go to RESP.
  - mem_ack while mem_req=0 is ignored.
- RESP: done=1 and busy=0 for exactly one cycle, then IDLE. A new req_valid in the RESP cycle is ignored. Earliest next accept is the following IDLE cycle.
- Latency: accept at edge N, mem_req high from N+1, ack at cycle M≥N+1, done at M+1. Zero-wait memory gives 3 cycles from req_valid to done.
- Byte enables, with o = addr[1:0]:
  - byte: 4'b0001<<o
  - half: 4'b0011<<o
  - word/fetch: 4'b1111
- Store data: SB replicates wdata[7:0] to all 4 lanes; SH replicates wdata[15:0] to both halves; SW passes through.
- Load formatting: select lane by o, then sign-extend (LB, LH) or zero-extend (LBU, LHU); LW and fetch pass through.
- err: cleared on every accept; meaningful only during done.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A 10-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, go to RESP with err=1, leave rdata unchanged.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; REQ waits indefinitely.

Test Plan:
- LW addr 0x100, mem_ack on first REQ cycle, mem_rdata 0xDEADBEEF -> mem_addr 0x40, mem_be 1111, done 3 cycles after req_valid, rdata 0xDEADBEEF, err 0.
- LB addr 0x103 then LBU addr 0x103, mem_rdata 0x80FF0011 -> mem_be 1000; LB rdata 0xFFFFFF80, LBU rdata 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD, ack after 4 wait cycles -> mem_we 1, mem_be 1100, mem_wdata 0xABCDABCD held stable throughout REQ, done on the cycle after ack.
- LW addr 0x101 and funct3=011 -> no mem_req, done with err 1, 2 cycles after req_valid.
- rst asserted during REQ with no ack -> next cycle mem_req 0, busy 0, done 0; a later request completes normally.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=8, fetch with no ack -> mem_req drops after 8 REQ cycles, done with err 1.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Word-addressed, byte-enabled memory bus with a req/ack handshake.
// master = mem_access_ctrl side, slave = memory side.
interface mem_access_ctrl_if;
   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [BE_W-1:0]   mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-side executor for the multicycle core: one fetch/load/store per transaction.
// Optional mem_ack timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_fetch,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   mem_access_ctrl_if.master mem
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 30;
   localparam int unsigned CNT_W  = 10;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
      $error("mem_access_ctrl: TIMEOUT_CYCLES must be within 1..1023");
   end

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

   // Request attributes needed later to format the returned word
   typedef struct packed {
      logic       fetch;
      logic [2:0] funct3;
      logic [1:0] off;
   } req_t;

   state_e              state_q, state_d;
   req_t                req_q, req_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]          mem_be_q, mem_be_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
`endif

   logic [1:0]  off_c;
   logic        illegal_c;
   logic        store_c;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;

   assign off_c   = req_addr[1:0];
   assign store_c = req_we & ~req_fetch;

   // Access legality, byte enables and lane-replicated store data for the incoming request
   always_comb begin
      illegal_c = 1'b0;
      be_c      = 4'b1111;
      wdata_c   = req_wdata;
      if (req_fetch) begin
         illegal_c = (off_c != 2'b00);
      end else begin
         unique case (req_funct3[1:0])
            2'b00: begin
               be_c    = 4'(4'b0001 << off_c);
               wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
               illegal_c = off_c[0];
               be_c      = 4'(4'b0011 << off_c);
               wdata_c   = {2{req_wdata[15:0]}};
            end
            2'b10:   illegal_c = (off_c != 2'b00) | req_funct3[2];
            default: illegal_c = 1'b1;
         endcase
         if (req_we && req_funct3[2]) illegal_c = 1'b1;
      end
      if (!store_c) wdata_c = '0;
   end

   function automatic logic [31:0] fmt_load(input logic [31:0] w, input req_t r);
      logic [31:0] sh;
      logic [31:0] res;
      sh  = w >> {r.off, 3'b000};
      res = w;
      if (!r.fetch) begin
         unique case (r.funct3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b100:  res = {24'h0, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b101:  res = {16'h0, sh[15:0]};
            default: res = w;
         endcase
      end
      return res;
   endfunction

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_d = '{fetch: req_fetch, funct3: req_funct3, off: off_c};
               if (illegal_c) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d     = S_REQ;
                  busy_d      = 1'b1;
                  err_d       = 1'b0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = store_c;
                  mem_addr_d  = req_addr[31:2];
                  mem_be_d    = be_c;
                  mem_wdata_d = wdata_c;
`ifdef MEM_ACCESS_TIMEOUT_EN
                  to_cnt_d    = '0;
`endif
               end
            end
         end
         S_REQ: begin
            if (mem.mem_ack) begin
               if (!mem_we_q) rdata_d = fmt_load(mem.mem_rdata, req_q);
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = S_RESP;
               done_d    = 1'b1;
               busy_d    = 1'b0;
            end
`ifdef MEM_ACCESS_TIMEOUT_EN
            // Timeout fires on the TIMEOUT_CYCLES-th unacknowledged REQ cycle
            else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = S_RESP;
               err_d     = 1'b1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
            end else begin
               to_cnt_d = to_cnt_q + CNT_W'(1);
            end
`endif
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign rdata         = rdata_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed plan items plus random transactions
// against a byte-lane arithmetic reference model; the bench also plays the memory.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_fetch, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        busy, done, err;
   logic [31:0] rdata;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_rdata = 32'h0;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_fetch  (req_fetch),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .rdata      (rdata),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Access size in bytes, 0 for an undefined funct3
   function automatic int unsigned size_m(input bit fetch, input logic [2:0] f3);
      if (fetch) return 4;
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit legal_m(input bit fetch, input bit we, input logic [2:0] f3,
                                  input logic [31:0] addr);
      int unsigned sz;
      sz = size_m(fetch, f3);
      if (sz == 0) return 1'b0;
      if (!fetch && we && f3 >= 3'd4) return 1'b0;
      return (addr % sz) == 0;
   endfunction

   function automatic logic [3:0] be_m(input bit fetch, input logic [2:0] f3, input logic [31:0] addr);
      int unsigned sz;
      int unsigned o;
      sz = size_m(fetch, f3);
      o  = addr % 4;
      return 4'(((1 << sz) - 1) << o);
   endfunction

   function automatic logic [31:0] wdata_m(input logic [2:0] f3, input logic [31:0] w);
      case (size_m(1'b0, f3))
         1:       return 32'(w[7:0]) * 32'h0101_0101;
         2:       return 32'(w[15:0]) * 32'h0001_0001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] load_m(input bit fetch, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] word);
      int unsigned bits;
      int unsigned o;
      logic [31:0] mask;
      logic [31:0] v;
      if (size_m(fetch, f3) == 4) return word;
      bits = 8 * size_m(fetch, f3);
      o    = addr % 4;
      mask = (32'h1 << bits) - 32'h1;
      v    = (word >> (8 * o)) & mask;
      if (f3 < 3'd4 && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   // Starts and ends just after a falling edge; ack after `waits` unacknowledged REQ cycles
   task automatic txn(input string tag, input bit fetch, input bit we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] word, input int waits);
      bit lg;
      bit st;
      lg = legal_m(fetch, we, f3, addr);
      st = we && !fetch;
      req_valid = 1'b1; req_fetch = fetch; req_we = we;
      req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      if (!lg) begin
         chk({tag, " ill_done"}, 32'(done), 32'h1);
         chk({tag, " ill_err"}, 32'(err), 32'h1);
         chk({tag, " ill_busy"}, 32'(busy), 32'h0);
         chk({tag, " ill_memreq"}, 32'(bus.mem_req), 32'h0);
         chk({tag, " ill_rdata"}, rdata, exp_rdata);
      end else begin
         chk({tag, " busy"}, 32'(busy), 32'h1);
         chk({tag, " early_done"}, 32'(done), 32'h0);
         for (int i = 0; i <= waits; i++) begin
            chk({tag, " mem_req"}, 32'(bus.mem_req), 32'h1);
            chk({tag, " mem_addr"}, 32'(bus.mem_addr), addr >> 2);
            chk({tag, " mem_be"}, 32'(bus.mem_be), 32'(be_m(fetch, f3, addr)));
            chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(st));
            if (st) chk({tag, " mem_wdata"}, bus.mem_wdata, wdata_m(f3, wdata));
            bus.mem_ack   = (i == waits);
            bus.mem_rdata = (i == waits) ? word : $urandom;
            @(negedge clk);
         end
         bus.mem_ack = 1'b0;
         if (!st) exp_rdata = load_m(fetch, f3, addr, word);
         chk({tag, " done"}, 32'(done), 32'h1);
         chk({tag, " err"}, 32'(err), 32'h0);
         chk({tag, " busy_resp"}, 32'(busy), 32'h0);
         chk({tag, " memreq_drop"}, 32'(bus.mem_req), 32'h0);
         chk({tag, " rdata"}, rdata, exp_rdata);
      end
      // A request presented during the done cycle must be ignored
      req_valid = 1'b1; req_fetch = 1'b0; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, " done_pulse"}, 32'(done), 32'h0);
      chk({tag, " resp_ignore_busy"}, 32'(busy), 32'h0);
      chk({tag, " resp_ignore_req"}, 32'(bus.mem_req), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_fetch = 1'b0; req_we = 1'b0;
      req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst done", 32'(done), 32'h0);
      chk("rst err", 32'(err), 32'h0);
      chk("rst rdata", rdata, 32'h0);
      chk("rst mem_req", 32'(bus.mem_req), 32'h0);
      chk("rst mem_we", 32'(bus.mem_we), 32'h0);
      chk("rst mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst mem_be", 32'(bus.mem_be), 32'h0);
      chk("rst mem_wdata", bus.mem_wdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      txn("lw100", 1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
      chk("lw100 const", rdata, 32'hDEAD_BEEF);
      txn("lb103", 1'b0, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0011, 1);
      chk("lb103 const", rdata, 32'hFFFF_FF80);
      txn("lbu103", 1'b0, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0011, 0);
      chk("lbu103 const", rdata, 32'h0000_0080);
      txn("sh202", 1'b0, 1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 4);
      chk("sh202 keeps rdata", rdata, 32'h0000_0080);
      txn("lw101", 1'b0, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
      txn("f3_011", 1'b0, 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
      txn("sbu", 1'b0, 1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0);
      txn("fetch_mis", 1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h0, 0);
      txn("fetch", 1'b1, 1'b1, 3'd7, 32'h400, 32'h0, 32'h0000_0013, 2);

      // Stray ack while idle must not complete anything
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("idle_ack done", 32'(done), 32'h0);
      chk("idle_ack rdata", rdata, exp_rdata);

      // Reset in the middle of REQ aborts the transaction silently
      req_valid = 1'b1; req_fetch = 1'b0; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80;
      @(negedge clk);
      req_valid = 1'b0;
      chk("midrst pre mem_req", 32'(bus.mem_req), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_rdata = 32'h0;
      chk("midrst mem_req", 32'(bus.mem_req), 32'h0);
      chk("midrst busy", 32'(busy), 32'h0);
      chk("midrst done", 32'(done), 32'h0);
      @(negedge clk);
      chk("midrst no_done", 32'(done), 32'h0);
      txn("post_rst", 1'b0, 1'b0, 3'd5, 32'h82, 32'h0, 32'hC001_7E57, 1);

`ifdef MEM_ACCESS_TIMEOUT_EN
      req_valid = 1'b1; req_fetch = 1'b1; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h40;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("to mem_req", 32'(bus.mem_req), 32'h1);
         @(negedge clk);
      end
      chk("to done", 32'(done), 32'h1);
      chk("to err", 32'(err), 32'h1);
      chk("to mem_req_drop", 32'(bus.mem_req), 32'h0);
      chk("to rdata", rdata, exp_rdata);
      @(negedge clk);
      chk("to done_pulse", 32'(done), 32'h0);
`endif

      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         txn("rand", ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), a, $urandom, $urandom, int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
